// File: rtl/l1_ahb_mtx_out_arb.sv
// Output-port arbiter for the L1 AHB bus matrix: picks the address-phase owner among three
// inputs, holds it across defined-length bursts and locked sequences, tracks the data-phase owner.
module l1_ahb_mtx_out_arb #(
  parameter bit         RR_EN   = 1'b1,
  parameter logic [1:0] NO_PORT = 2'b11
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADYM,
  input  logic [2:0] sel_in,
  input  logic [5:0] trans_in,
  input  logic [8:0] burst_in,
  input  logic [2:0] mastlock_in,
  output logic [1:0] addr_in_port,
  output logic [1:0] data_in_port,
  output logic [2:0] active_in,
  output logic       hsel_out,
  output logic       hmastlock_out
);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  localparam logic [2:0] BuSingle = 3'd0;
  localparam logic [2:0] BuIncr   = 3'd1;

  logic [1:0] addr_q, addr_d;
  logic [1:0] data_q, data_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hold_q, hold_d;

  logic       own_valid, own_sel, own_lock;
  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic [1:0] start, pick;
  logic [2:0] idx;
  logic       found;

  // Current owner's request signals; NO_PORT selects nothing.
  always_comb begin
    own_valid = 1'b0;
    own_sel   = 1'b0;
    own_lock  = 1'b0;
    own_trans = TrIdle;
    own_burst = BuSingle;
    active_in = 3'b000;
    if (addr_q != NO_PORT) begin
      case (addr_q)
        2'd0: begin
          own_valid = 1'b1; own_sel = sel_in[0]; own_lock = mastlock_in[0];
          own_trans = trans_in[1:0]; own_burst = burst_in[2:0]; active_in = 3'b001;
        end
        2'd1: begin
          own_valid = 1'b1; own_sel = sel_in[1]; own_lock = mastlock_in[1];
          own_trans = trans_in[3:2]; own_burst = burst_in[5:3]; active_in = 3'b010;
        end
        2'd2: begin
          own_valid = 1'b1; own_sel = sel_in[2]; own_lock = mastlock_in[2];
          own_trans = trans_in[5:4]; own_burst = burst_in[8:6]; active_in = 3'b100;
        end
        default: ;
      endcase
    end
  end

  assign hsel_out      = own_valid & own_sel;
  assign hmastlock_out = own_valid & own_lock;

  // Hold state derived from what the owner presents in the address phase completing now.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = 1'b0;
    if (!hsel_out) begin
      cnt_d = 4'd0;
    end else begin
      unique case (own_trans)
        TrIdle: cnt_d = 4'd0;
        TrBusy: hold_d = hold_q;
        TrNonseq: begin
          case (own_burst)
            3'd2, 3'd3: cnt_d = 4'd3;
            3'd4, 3'd5: cnt_d = 4'd7;
            3'd6, 3'd7: cnt_d = 4'd15;
            default:    cnt_d = 4'd0;
          endcase
          hold_d = (cnt_d != 4'd0) || (own_burst == BuIncr);
        end
        TrSeq: begin
          if (own_burst == BuIncr) begin
            cnt_d  = 4'd0;
            hold_d = 1'b1;
          end else begin
            cnt_d  = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            hold_d = (cnt_d != 4'd0);
          end
        end
        default: ;
      endcase
      if (own_lock) hold_d = 1'b1;
    end
  end

  always_comb begin
    start = RR_EN ? ptr_q : 2'd0;
    found = 1'b0;
    pick  = NO_PORT;
    idx   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, start} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && sel_in[idx[1:0]]) begin
        found = 1'b1;
        pick  = idx[1:0];
      end
    end
  end

  always_comb begin
    addr_d = (hsel_out && hold_d) ? addr_q : pick;
    ptr_d  = ptr_q;
    if (addr_d != addr_q && addr_d != NO_PORT) ptr_d = (addr_d == 2'd2) ? 2'd0 : addr_d + 2'd1;
    data_d = (hsel_out && (own_trans == TrNonseq || own_trans == TrSeq)) ? addr_q : NO_PORT;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q <= NO_PORT;
      data_q <= NO_PORT;
      ptr_q  <= 2'd0;
      cnt_q  <= 4'd0;
      hold_q <= 1'b0;
    end else if (HREADYM) begin
      addr_q <= addr_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign addr_in_port = addr_q;
  assign data_in_port = data_q;

endmodule

// File: tb/tb_l1_ahb_mtx_out_arb.sv
// Directed bench for l1_ahb_mtx_out_arb: a round-robin and a fixed-priority instance share stimulus.
module tb_l1_ahb_mtx_out_arb;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, WRAP8 = 3'd4, INCR8 = 3'd5;

  logic       clk = 1'b0;
  logic       rst, hready;
  logic [2:0] sel, lock;
  logic [5:0] trans;
  logic [8:0] burst;

  logic [1:0] rr_addr, rr_data, fp_addr, fp_data;
  logic [2:0] rr_active, fp_active;
  logic       rr_hsel, rr_lock, fp_hsel, fp_lock;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  l1_ahb_mtx_out_arb #(.RR_EN(1'b1), .NO_PORT(2'b11)) u_rr (
    .HCLK(clk), .HRESET(rst), .HREADYM(hready), .sel_in(sel), .trans_in(trans),
    .burst_in(burst), .mastlock_in(lock), .addr_in_port(rr_addr), .data_in_port(rr_data),
    .active_in(rr_active), .hsel_out(rr_hsel), .hmastlock_out(rr_lock)
  );

  l1_ahb_mtx_out_arb #(.RR_EN(1'b0), .NO_PORT(2'b11)) u_fp (
    .HCLK(clk), .HRESET(rst), .HREADYM(hready), .sel_in(sel), .trans_in(trans),
    .burst_in(burst), .mastlock_in(lock), .addr_in_port(fp_addr), .data_in_port(fp_data),
    .active_in(fp_active), .hsel_out(fp_hsel), .hmastlock_out(fp_lock)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic s, input logic [1:0] t, input logic [2:0] b,
                        input logic l);
    sel[i]        = s;
    trans[2*i+:2] = t;
    burst[3*i+:3] = b;
    lock[i]       = l;
  endtask

  task automatic do_reset();
    rst = 1'b1; hready = 1'b1; sel = '0; trans = '0; burst = '0; lock = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hready = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, NSEQ, SINGLE, 1'b1);
    tick();
    nvec++;
    if ({rr_addr, rr_data, rr_active, rr_hsel, rr_lock} !== {2'd3, 2'd3, 3'b000, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_rr got addr=%0d data=%0d act=%b hsel=%b lock=%b exp 3 3 000 0 0",
               rr_addr, rr_data, rr_active, rr_hsel, rr_lock);
    end
    nvec++;
    if ({fp_addr, fp_data, fp_active, fp_hsel, fp_lock} !== {2'd3, 2'd3, 3'b000, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_fp got addr=%0d data=%0d act=%b hsel=%b lock=%b exp 3 3 000 0 0",
               fp_addr, fp_data, fp_active, fp_hsel, fp_lock);
    end
    rst = 1'b0;
    tick();
    nvec++;
    if ({rr_addr, rr_data, rr_active, rr_hsel, rr_lock} !== {2'd0, 2'd3, 3'b001, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL reset_release got addr=%0d data=%0d act=%b hsel=%b lock=%b exp 0 3 001 1 1",
               rr_addr, rr_data, rr_active, rr_hsel, rr_lock);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ea [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [1:0] ed [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, NSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      nvec++;
      if ({rr_addr, rr_data} !== {ea[k], ed[k]}) begin
        nerr++;
        $display("FAIL rr_seq[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                 k, rr_addr, rr_data, ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_incr4();
    logic [1:0] ea;
    do_reset();
    set_in(1, 1'b1, NSEQ, INCR4, 1'b0);
    tick();
    nvec++;
    if (rr_addr !== 2'd1) begin
      nerr++;
      $display("FAIL incr4_grant got addr=%0d exp 1", rr_addr);
    end
    set_in(0, 1'b1, NSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      trans[3:2] = (k == 0) ? NSEQ : SEQ;
      tick();
      ea = (k < 3) ? 2'd1 : 2'd0;
      nvec++;
      if ({rr_addr, rr_data} !== {ea, 2'd1}) begin
        nerr++;
        $display("FAIL incr4_beat[%0d] got addr=%0d data=%0d exp addr=%0d data=1",
                 k, rr_addr, rr_data, ea);
      end
    end
  endtask

  task automatic test_wrap8_wait();
    logic [1:0] tr [11] = '{NSEQ, SEQ, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       hr [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] ea [11] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    logic [1:0] ed [11] = '{2, 2, 2, 2, 2, 3, 2, 2, 2, 2, 2};
    do_reset();
    set_in(2, 1'b1, NSEQ, WRAP8, 1'b0);
    tick();
    set_in(0, 1'b1, NSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 11; k++) begin
      trans[5:4] = tr[k];
      hready     = hr[k];
      tick();
      nvec++;
      if ({rr_addr, rr_data} !== {ea[k], ed[k]}) begin
        nerr++;
        $display("FAIL wrap8_step[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                 k, rr_addr, rr_data, ea[k], ed[k]);
      end
    end
    hready = 1'b1;
  endtask

  task automatic test_idle_term();
    logic [1:0] tr [4] = '{NSEQ, NSEQ, SEQ, IDLE};
    logic [1:0] ea [4] = '{0, 0, 0, 1};
    logic [1:0] ed [4] = '{3, 0, 0, 3};
    do_reset();
    set_in(0, 1'b1, NSEQ, INCR8, 1'b0);
    set_in(1, 1'b1, NSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      trans[1:0] = tr[k];
      tick();
      nvec++;
      if ({rr_addr, rr_data} !== {ea[k], ed[k]}) begin
        nerr++;
        $display("FAIL idle_term[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d",
                 k, rr_addr, rr_data, ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_mastlock();
    do_reset();
    set_in(1, 1'b1, NSEQ, SINGLE, 1'b1);
    tick();
    set_in(0, 1'b1, NSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({fp_addr, fp_lock, fp_active} !== {2'd1, 1'b1, 3'b010}) begin
        nerr++;
        $display("FAIL lock_xfer[%0d] got addr=%0d lock=%b act=%b exp 1 1 010",
                 k, fp_addr, fp_lock, fp_active);
      end
      tick();
    end
    nvec++;
    if ({fp_addr, fp_lock} !== {2'd1, 1'b1}) begin
      nerr++;
      $display("FAIL lock_last got addr=%0d lock=%b exp 1 1", fp_addr, fp_lock);
    end
    set_in(1, 1'b1, IDLE, SINGLE, 1'b0);
    tick();
    nvec++;
    if ({fp_addr, fp_lock, fp_active} !== {2'd0, 1'b0, 3'b001}) begin
      nerr++;
      $display("FAIL lock_drop got addr=%0d lock=%b act=%b exp 0 0 001",
               fp_addr, fp_lock, fp_active);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1, 1'b1, NSEQ, SINGLE, 1'b1);
    tick();
    set_in(0, 1'b1, NSEQ, SINGLE, 1'b0);
    tick();
    nvec++;
    if (fp_addr !== 2'd1) begin
      nerr++;
      $display("FAIL midrst_pre got addr=%0d exp 1", fp_addr);
    end
    rst = 1'b1;
    tick();
    nvec++;
    if ({fp_addr, fp_data, fp_active, fp_hsel, fp_lock} !== {2'd3, 2'd3, 3'b000, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL midrst got addr=%0d data=%0d act=%b hsel=%b lock=%b exp 3 3 000 0 0",
               fp_addr, fp_data, fp_active, fp_hsel, fp_lock);
    end
    rst = 1'b0;
    tick();
    nvec++;
    if ({fp_addr, rr_addr} !== {2'd0, 2'd0}) begin
      nerr++;
      $display("FAIL midrst_after got fp=%0d rr=%0d exp 0 0", fp_addr, rr_addr);
    end
  endtask

  initial begin
    rst = 1'b1; hready = 1'b1; sel = '0; trans = '0; burst = '0; lock = '0;
    test_reset();
    test_round_robin();
    test_incr4();
    test_wrap8_wait();
    test_idle_term();
    test_mastlock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
